// File: rtl/byte_striping_pkg.sv
// Shared definitions for the striping, recirculator and unstriping stages.
// Holds the lane count, the link state encoding and the default pad byte.
package byte_striping_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [7:0] DEFAULT_PAD_BYTE = 8'h00;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } stripeState_t;

endpackage

// File: rtl/byte_striping.sv
// Distributes a byte stream round-robin over four lanes, one group per four bytes.
// Latency: 1 cycle from the 4th byte to the lane valids. There is no backpressure; every valid byte is taken.
module byte_striping
  import byte_striping_pkg::*;
#(
  parameter int         IDLE_LIMIT = 4,
  parameter logic [7:0] PAD_BYTE   = DEFAULT_PAD_BYTE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] dataOut0,
  output logic [7:0] dataOut1,
  output logic [7:0] dataOut2,
  output logic [7:0] dataOut3,
  output logic       validOut0,
  output logic       validOut1,
  output logic       validOut2,
  output logic       validOut3,
  output logic       selector_IDLE
);

  localparam int IDLE_CNT_W = $clog2(IDLE_LIMIT + 1);

  stripeState_t          state;
  logic [1:0]            ptr;
  logic [IDLE_CNT_W-1:0] idleCnt;
  logic [7:0]            bufDat  [NUM_LANES];
  logic [7:0]            laneDat [NUM_LANES];
  logic [NUM_LANES-1:0]  laneVld;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= 2'd0;
      idleCnt       <= '0;
      laneVld       <= '0;
      selector_IDLE <= 1'b1;
      for (int i = 0; i < NUM_LANES; i++) begin
        bufDat[i]  <= 8'h00;
        laneDat[i] <= 8'h00;
      end
    end else begin
      laneVld <= '0;
      if (valid_in) begin
        bufDat[ptr]   <= data_in;
        ptr           <= ptr + 2'd1;
        idleCnt       <= '0;
        state         <= ACTIVE;
        selector_IDLE <= 1'b0;
        if (ptr == 2'd3) begin
          laneDat[0] <= bufDat[0];
          laneDat[1] <= bufDat[1];
          laneDat[2] <= bufDat[2];
          laneDat[3] <= data_in;
          laneVld    <= '1;
        end
      end else if (state == ACTIVE) begin
        if (idleCnt == IDLE_CNT_W'(IDLE_LIMIT - 1)) begin
          // Link went quiet: close out whatever partial group is buffered.
          state         <= IDLE;
          selector_IDLE <= 1'b1;
          idleCnt       <= '0;
          ptr           <= 2'd0;
          if (ptr != 2'd0) begin
            for (int i = 0; i < NUM_LANES; i++) begin
              if (i < int'(ptr)) begin
                laneDat[i] <= bufDat[i];
                laneVld[i] <= 1'b1;
              end else begin
                laneDat[i] <= PAD_BYTE;
              end
            end
          end
        end else if (idleCnt != IDLE_CNT_W'(IDLE_LIMIT)) begin
          idleCnt <= idleCnt + IDLE_CNT_W'(1);
        end
      end else begin
        idleCnt       <= '0;
        selector_IDLE <= 1'b1;
      end
    end
  end

  assign dataOut0  = laneDat[0];
  assign dataOut1  = laneDat[1];
  assign dataOut2  = laneDat[2];
  assign dataOut3  = laneDat[3];
  assign validOut0 = laneVld[0];
  assign validOut1 = laneVld[1];
  assign validOut2 = laneVld[2];
  assign validOut3 = laneVld[3];

endmodule

// File: tb/tb_byte_striping.sv
// Directed bench for byte_striping: reset, full groups, partial flush, idle boundary, reset mid-group.
module tb_byte_striping;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic [7:0] dataOut0, dataOut1, dataOut2, dataOut3;
  logic       validOut0, validOut1, validOut2, validOut3;
  logic       selector_IDLE;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  byte_striping #(
    .IDLE_LIMIT(4),
    .PAD_BYTE  (8'hEE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .dataOut0     (dataOut0),
    .dataOut1     (dataOut1),
    .dataOut2     (dataOut2),
    .dataOut3     (dataOut3),
    .validOut0    (validOut0),
    .validOut1    (validOut1),
    .validOut2    (validOut2),
    .validOut3    (validOut3),
    .selector_IDLE(selector_IDLE)
  );

  wire [31:0] lanes = {dataOut0, dataOut1, dataOut2, dataOut3};
  wire [3:0]  vlds  = {validOut0, validOut1, validOut2, validOut3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one input for one rising edge, then settle 1 time unit past it.
  task automatic step(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] grp;
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;

    // Reset
    step(0, 8'h00);
    step(0, 8'h00);
    chk("rst_vld", {28'd0, vlds}, 32'h0);
    chk("rst_dat", lanes, 32'h0000_0000);
    chk("rst_sel", {31'd0, selector_IDLE}, 32'd1);
    reset = 1'b0;

    // Full group; selector drops right after the first byte
    step(1, 8'h11);
    chk("g1_sel_fall", {31'd0, selector_IDLE}, 32'd0);
    chk("g1_vld_b0", {28'd0, vlds}, 32'h0);
    step(1, 8'h22);
    step(1, 8'h33);
    chk("g1_vld_b2", {28'd0, vlds}, 32'h0);
    step(1, 8'h44);
    chk("g1_dat", lanes, 32'h1122_3344);
    chk("g1_vld", {28'd0, vlds}, 32'hF);
    step(0, 8'h00);
    chk("g1_vld_drop", {28'd0, vlds}, 32'h0);
    chk("g1_dat_hold", lanes, 32'h1122_3344);
    step(0, 8'h00);
    step(0, 8'h00);
    chk("g1_idle3_sel", {31'd0, selector_IDLE}, 32'd0);
    step(0, 8'h00);
    chk("g1_idle4_sel", {31'd0, selector_IDLE}, 32'd1);
    chk("g1_noflush_vld", {28'd0, vlds}, 32'h0);
    chk("g1_noflush_dat", lanes, 32'h1122_3344);

    // Partial flush with padding
    step(1, 8'hA1);
    step(1, 8'hA2);
    step(0, 8'h00);
    step(0, 8'h00);
    step(0, 8'h00);
    chk("fl_pre_sel", {31'd0, selector_IDLE}, 32'd0);
    chk("fl_pre_vld", {28'd0, vlds}, 32'h0);
    step(0, 8'h00);
    chk("fl_dat", lanes, 32'hA1A2_EEEE);
    chk("fl_vld", {28'd0, vlds}, 32'hC);
    chk("fl_sel", {31'd0, selector_IDLE}, 32'd1);
    step(0, 8'h00);
    chk("fl_after_vld", {28'd0, vlds}, 32'h0);
    chk("fl_after_sel", {31'd0, selector_IDLE}, 32'd1);

    // Byte then 3 idle cycles, repeated: never flushes or idles
    for (int k = 0; k < 8; k++) begin
      step(1, 8'hB0 + 8'(k));
      if (k % 4 == 3) begin
        grp = (k == 3) ? 32'hB0B1_B2B3 : 32'hB4B5_B6B7;
        chk("ct_vld", {28'd0, vlds}, 32'hF);
        chk("ct_dat", lanes, grp);
      end else begin
        chk("ct_vld0", {28'd0, vlds}, 32'h0);
      end
      for (int j = 0; j < 3; j++) begin
        step(0, 8'h00);
        chk("ct_idle_sel", {31'd0, selector_IDLE}, 32'd0);
        chk("ct_idle_vld", {28'd0, vlds}, 32'h0);
      end
    end
    step(0, 8'h00);
    chk("ct_end_sel", {31'd0, selector_IDLE}, 32'd1);
    chk("ct_end_vld", {28'd0, vlds}, 32'h0);

    // Back-to-back 01..0C
    for (int i = 0; i < 12; i++) begin
      step(1, 8'(i + 1));
      if (i % 4 == 3) begin
        grp = (i == 3) ? 32'h0102_0304 : (i == 7) ? 32'h0506_0708 : 32'h090A_0B0C;
        chk("bb_vld", {28'd0, vlds}, 32'hF);
        chk("bb_dat", lanes, grp);
      end else begin
        chk("bb_vld0", {28'd0, vlds}, 32'h0);
      end
      chk("bb_sel", {31'd0, selector_IDLE}, 32'd0);
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00);
    chk("bb_end_sel", {31'd0, selector_IDLE}, 32'd1);
    chk("bb_end_vld", {28'd0, vlds}, 32'h0);

    // Reset mid-group discards buffered bytes
    step(1, 8'h55);
    step(1, 8'h66);
    reset = 1'b1;
    step(0, 8'h00);
    chk("mr_vld", {28'd0, vlds}, 32'h0);
    chk("mr_dat", lanes, 32'h0000_0000);
    chk("mr_sel", {31'd0, selector_IDLE}, 32'd1);
    reset = 1'b0;
    step(1, 8'h77);
    chk("mr_sel_fall", {31'd0, selector_IDLE}, 32'd0);
    chk("mr_vld_b0", {28'd0, vlds}, 32'h0);
    step(1, 8'h88);
    step(1, 8'h99);
    chk("mr_vld_b2", {28'd0, vlds}, 32'h0);
    chk("mr_dat_b2", lanes, 32'h0000_0000);
    step(1, 8'hAA);
    chk("mr_dat", lanes, 32'h7788_99AA);
    chk("mr_vld_grp", {28'd0, vlds}, 32'hF);
    step(0, 8'h00);
    chk("mr_vld_drop", {28'd0, vlds}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
